// File: rtl/vpu_scratchpad.sv
// Operand scratchpad for vpu_top: dual-operand reads with fixed latency, single-word
// writes, and a host preload port that takes priority over VPU requests.
module vpu_scratchpad #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    input  logic [DATA_W-1:0] data_c,
    output logic              mem_rdy,
    output logic              mem_valid,
    output logic [DATA_W-1:0] data_a,
    output logic [DATA_W-1:0] data_b,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              oob_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT_W = 3;
    localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] snap_a_q, snap_a_d;
    logic [DATA_W-1:0] snap_b_q, snap_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              mem_valid_q, mem_valid_d;
    logic              oob_q, oob_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              a_in_c, b_in_c, c_in_c, h_in_c;
    logic [IDX_W-1:0]  a_idx_c, b_idx_c, c_idx_c, h_idx_c;
    logic [DATA_W-1:0] rd_a_c, rd_b_c;
    logic              accept_c, rd_acc_c, wr_acc_c;

    // Address decode: range check against DEPTH and word index
    assign a_in_c  = {1'b0, addr_a}    < DEPTH_X;
    assign b_in_c  = {1'b0, addr_b}    < DEPTH_X;
    assign c_in_c  = {1'b0, addr_c}    < DEPTH_X;
    assign h_in_c  = {1'b0, host_addr} < DEPTH_X;
    assign a_idx_c = addr_a[IDX_W-1:0];
    assign b_idx_c = addr_b[IDX_W-1:0];
    assign c_idx_c = addr_c[IDX_W-1:0];
    assign h_idx_c = host_addr[IDX_W-1:0];

    assign rd_a_c = a_in_c ? mem_q[a_idx_c] : '0;
    assign rd_b_c = b_in_c ? mem_q[b_idx_c] : '0;

    // Host write strobe steals the accept slot; reset forces not-ready
    assign mem_rdy  = (state_q == ST_IDLE) && !host_we && rst;
    assign accept_c = req_valid && mem_rdy;
    assign rd_acc_c = accept_c && !req_we;
    assign wr_acc_c = accept_c && req_we;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_acc_c) begin
                    if (RD_LAT == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d   = ST_RD_WAIT;
                        lat_cnt_d = LAT_INIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: response data is loaded on entry to RESP and then held
    always_comb begin
        mem_valid_d = (state_d == ST_RESP);
        data_a_d    = data_a_q;
        data_b_d    = data_b_q;
        if (state_d == ST_RESP) begin
            data_a_d = (state_q == ST_IDLE) ? rd_a_c : snap_a_q;
            data_b_d = (state_q == ST_IDLE) ? rd_b_c : snap_b_q;
        end
    end

    // Storage, read snapshot and sticky out-of-range flag
    always_comb begin
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        oob_d    = oob_q;
        mem_d    = mem_q;
        if (rd_acc_c) begin
            snap_a_d = rd_a_c;
            snap_b_d = rd_b_c;
            if (!a_in_c || !b_in_c) begin
                oob_d = 1'b1;
            end
        end
        if (wr_acc_c) begin
            if (c_in_c) begin
                mem_d[c_idx_c] = data_c;
            end else begin
                oob_d = 1'b1;
            end
        end
        if (host_we) begin
            if (h_in_c) begin
                mem_d[h_idx_c] = host_wdata;
            end else begin
                oob_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_a_q    <= '0;
            snap_b_q    <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            mem_valid_q <= 1'b0;
            oob_q       <= 1'b0;
            mem_q       <= '{default: '0};
        end else begin
            snap_a_q    <= snap_a_d;
            snap_b_q    <= snap_b_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            mem_valid_q <= mem_valid_d;
            oob_q       <= oob_d;
            mem_q       <= mem_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign data_a    = data_a_q;
    assign data_b    = data_b_q;
    assign oob_err   = oob_q;

endmodule

// File: tb/tb_vpu_scratchpad.sv
// Bench for vpu_scratchpad: directed scenarios plus random traffic checked every
// cycle against a cycle-count reference model of the scratchpad.
module tb_vpu_scratchpad;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned IDX_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] addr_a = '0;
    logic [ADDR_W-1:0] addr_b = '0;
    logic [ADDR_W-1:0] addr_c = '0;
    logic [DATA_W-1:0] data_c = '0;
    logic              mem_rdy;
    logic              mem_valid;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              host_we = 1'b0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [DATA_W-1:0] host_wdata = '0;
    logic              oob_err;

    vpu_scratchpad #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c), .data_c(data_c),
        .mem_rdy(mem_rdy), .mem_valid(mem_valid),
        .data_a(data_a), .data_b(data_b),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: memory image, sticky flag, and the cycle a response is due
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              ref_oob;
    int                cyc_n;
    int                resp_cyc;
    logic [DATA_W-1:0] pend_a, pend_b, last_a, last_b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (a < DEPTH) return ref_mem[a[IDX_W-1:0]];
        return '0;
    endfunction

    // One clock cycle: drive, check all outputs mid-cycle, then advance the model
    task automatic run_cycle(input logic rv, input logic we,
                             input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ab,
                             input logic [ADDR_W-1:0] ac, input logic [DATA_W-1:0] dc,
                             input logic hwe, input logic [ADDR_W-1:0] ha,
                             input logic [DATA_W-1:0] hd, output logic acc);
        logic exp_rdy;
        req_valid = rv; req_we = we; addr_a = aa; addr_b = ab; addr_c = ac; data_c = dc;
        host_we = hwe; host_addr = ha; host_wdata = hd;
        exp_rdy = (cyc_n > resp_cyc) && !hwe;
        @(negedge clk);
        chk("mem_rdy", 64'(mem_rdy), 64'(exp_rdy));
        chk("mem_valid", 64'(mem_valid), 64'(cyc_n == resp_cyc));
        if (cyc_n == resp_cyc) begin
            last_a = pend_a;
            last_b = pend_b;
        end
        chk("data_a", 64'(data_a), 64'(last_a));
        chk("data_b", 64'(data_b), 64'(last_b));
        chk("oob_err", 64'(oob_err), 64'(ref_oob));
        acc = rv && exp_rdy;
        if (acc && !we) begin
            pend_a   = ref_read(aa);
            pend_b   = ref_read(ab);
            resp_cyc = cyc_n + int'(RD_LAT);
            if (aa >= DEPTH || ab >= DEPTH) ref_oob = 1'b1;
        end
        if (acc && we) begin
            if (ac < DEPTH) ref_mem[ac[IDX_W-1:0]] = dc;
            else ref_oob = 1'b1;
        end
        if (hwe) begin
            if (ha < DEPTH) ref_mem[ha[IDX_W-1:0]] = hd;
            else ref_oob = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) run_cycle(0, 0, '0, '0, '0, '0, 0, '0, '0, acc);
    endtask

    task automatic host_wr(input int a, input int d);
        logic acc;
        run_cycle(0, 0, '0, '0, '0, '0, 1, 16'(a), 32'(d), acc);
    endtask

    // VPU requests are held until accepted, with a bounded wait
    task automatic vpu_req(input logic we, input int a, input int b, input int c, input int d);
        logic acc;
        logic done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            run_cycle(1, we, 16'(a), 16'(b), 16'(c), 32'(d), 0, '0, '0, acc);
            done = acc;
        end
        if (!done) chk("req_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic rd(input int a, input int b);
        vpu_req(1'b0, a, b, 0, 0);
    endtask

    task automatic vpu_wr(input int c, input int d);
        vpu_req(1'b1, 0, 0, c, d);
    endtask

    task automatic drain();
        while (cyc_n <= resp_cyc) idle(1);
        idle(1);
    endtask

    task automatic read_all();
        for (int i = 0; i < int'(DEPTH) / 2; i++) rd(i, i + int'(DEPTH) / 2);
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b0; req_valid = 1'b0; host_we = 1'b0;
        #1;
        chk("rst_mem_rdy", 64'(mem_rdy), 64'(0));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_data_a", 64'(data_a), 64'(0));
        chk("rst_data_b", 64'(data_b), 64'(0));
        chk("rst_oob_err", 64'(oob_err), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_hold_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_hold_mem_rdy", 64'(mem_rdy), 64'(0));
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_oob  = 1'b0;
        pend_a   = '0; pend_b = '0; last_a = '0; last_b = '0;
        resp_cyc = -1;
        cyc_n++;
        rst = 1'b1;
    endtask

    initial begin
        logic acc;
        cyc_n = 0;
        do_reset();
        idle(2);

        // Host preload then timed read
        host_wr(3, 32'h11);
        host_wr(7, 32'h22);
        rd(3, 7);
        idle(3);
        chk("preload_data_a", 64'(data_a), 64'h11);
        chk("preload_data_b", 64'(data_b), 64'h22);

        // Read-after-write on consecutive cycles
        vpu_wr(5, 32'hDEAD);
        rd(5, 5);
        drain();
        chk("raw_data_a", 64'(data_a), 64'hDEAD);

        // Host write during an outstanding read is not seen by that read
        vpu_wr(4, 32'h1);
        rd(4, 4);
        host_wr(4, 32'h99);
        drain();
        chk("snapshot_data_a", 64'(data_a), 64'h1);
        rd(4, 3);
        drain();
        chk("later_read_data_a", 64'(data_a), 64'h99);

        // Host strobe blocks a held request for three cycles
        for (int i = 0; i < 3; i++)
            run_cycle(1, 0, 16'd3, 16'd7, '0, '0, 1, 16'(10 + i), 32'(32'h55 + i), acc);
        rd(10, 12);
        drain();

        // Out-of-range read and write
        rd(40, 3);
        drain();
        vpu_wr(40, 32'hBAD);
        idle(2);
        read_all();
        chk("oob_sticky", 64'(oob_err), 64'(1));

        // Reset one cycle after a read accept
        rd(3, 7);
        do_reset();
        idle(4);
        read_all();

        // Random traffic with a reset in the middle
        for (int i = 0; i < 800; i++) begin
            logic              rv, we, hwe;
            logic [ADDR_W-1:0] aa, ab, ac, ha;
            if (i == 400) do_reset();
            rv  = ($urandom_range(0, 9) < 6);
            we  = $urandom_range(0, 1) == 1;
            hwe = ($urandom_range(0, 99) < 15);
            aa  = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(32, 70)) : 16'($urandom_range(0, 31));
            ab  = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(32, 70)) : 16'($urandom_range(0, 31));
            ac  = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(32, 70)) : 16'($urandom_range(0, 31));
            ha  = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(32, 70)) : 16'($urandom_range(0, 31));
            run_cycle(rv, we, aa, ab, ac, 32'($urandom), hwe, ha, 32'($urandom), acc);
        end
        drain();
        read_all();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
